modn_counter: RTL and testbench
===============================

Name: modn_counter

Overview:
Synchronous, parametrised modulo-N counter that generalises the team's fixed mod-5 ripple counter.
- Single clock domain; no ripple clocks.
- Runtime-selectable modulus, up/down direction, synchronous clear and parallel load.
- Terminal-count output for cascading, plus a registered wrap pulse.
- Used as the base count/divider element in timer and sequencing blocks.

Parameters:
WIDTH, 3, counter width in bits; q and all value ports are WIDTH bits.
MOD_DEFAULT, 5, modulus used while mod_val == 0; legal range 2..2^WIDTH.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  reset, asynchronous, active-low.
en  input  1  count enable; one step per clock while high.
up_dn  input  1  1 = count up, 0 = count down.
clr  input  1  synchronous clear to 0.
load  input  1  synchronous parallel load.
load_val  input  WIDTH  value written on load.
mod_val  input  WIDTH  runtime modulus M; 0 selects MOD_DEFAULT; 1 is illegal (treated as 2).
q  output  WIDTH  current count.
tc  output  1  terminal count: en & (up_dn ? q >= M-1 : q == 0), combinational.
wrap_p  output  1  registered one-cycle pulse, high the cycle after a wrap occurred.

Behaviour:
- Reset: rst low → q = 0 and wrap_p = 0 immediately, independent of clk. Release is synchronous to the next rising edge; the first count happens on the first edge with rst high and en high.
- Effective modulus: M = (mod_val == 0) ? MOD_DEFAULT : max(mod_val, 2). M is sampled every cycle; no latching.
- Per-edge priority is clr > load > en.
  - clr: q ← 0; wrap_p ← 0.
  - load: q ← load_val, taken verbatim even if ≥ M; wrap_p ← 0.
  - en, up:
    - q ≥ M-1 → q ← 0, wrap_p ← 1.
    - else q ← q+1, wrap_p ← 0.
  - en, down:
    - q == 0 → q ← M-1, wrap_p ← 1.
    - q ≥ M → q ← M-1, wrap_p ← 0 (out-of-range recovery).
    - else q ← q-1, wrap_p ← 0.
  - No action asserted: q holds; wrap_p ← 0.
- Latency:
  - q changes one edge after the qualifying input.
  - tc is valid in the same cycle, so cascaded stage N+1 uses en = tc of stage N.
  - wrap_p lags the wrap edge by 0 cycles: it is registered with q, and is high while q shows the post-wrap value.
- Boundaries:
  - mod_val lowered below current q while counting up → wraps to 0 on the next enabled edge.
  - up_dn may change every cycle; the step direction is taken from the value at the edge.
  - M = 2^WIDTH (e.g. WIDTH=3, mod_val=0, MOD_DEFAULT=8) → natural binary wrap 7→0.
- Arithmetic: compare and step in WIDTH+1 bits so that M = 2^WIDTH does not overflow; the result is truncated to WIDTH.

Optional Feature:
MODN_COUNTER_GRAY_EN.
- Defined: adds output q_gray [WIDTH-1:0], registered, equal to q ^ (q >> 1), updated on the same edge as q and reset to 0 with rst. Used for safe cross-domain sampling of the count.
- Undefined: the q_gray port and its register are absent; all other behaviour is identical.

Decomposition:
- Package modn_counter_pkg:
  - DIR_UP = 1'b1, DIR_DOWN = 1'b0.
  - Function eff_mod(mod_val, MOD_DEFAULT, WIDTH) implementing the M rule.
  - Function bin2gray.
- Sub-module modn_next (purely combinational): inputs q, M, up_dn; outputs next_q and wrap.
- The top level holds the registers, priority mux, tc and the optional gray register.

Test Plan:
- Reset: rst low mid-count at q=3 → q=0 and wrap_p=0 asynchronously, before the next edge; hold en=1, release rst → sequence 0,1,2,…
- Default mod-5 up (WIDTH=3, mod_val=0, en=1, up_dn=1), 12 clocks → q: 1,2,3,4,0,1,…
  - tc high whenever q=4.
  - wrap_p high in each cycle where q has just become 0.
- Down with mod_val=6 → q: 0→5→4→3→2→1→0→5; tc high at q=0; wrap_p on each 0→5.
- Priority: clr=1, load=1, load_val=2, en=1 → q=0; next cycle clr=0, load=1 → q=2; load_val=7 with M=5 then up → q=0, wrap_p=1.
- Runtime modulus: q=6 with mod_val=0, MOD_DEFAULT=8; set mod_val=4 → next up edge q=0; down from q=6 with M=4 → q=3.
- Cascade: two instances, stage B en = tc of stage A, both M=5, 25 clocks → B increments once per 5 clocks and both read 0 at clock 25; with MODN_COUNTER_GRAY_EN defined, q_gray == q^(q>>1) every cycle.

Source files
------------

// File: rtl/modn_counter_pkg.sv
// modn_counter_pkg: shared types and helpers for the modulo-N counter slice.
//   dir_e     : count direction encoding (DIR_UP = 1, DIR_DOWN = 0)
//   eff_mod   : effective modulus from the runtime mod_val and the default
//   bin2gray  : binary to reflected Gray code
package modn_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // mod_val == 0 selects the default; 1 is meaningless for a counter and
    // is promoted to 2. mod_val is masked to the counter width first.
    function automatic int unsigned eff_mod(input int unsigned mod_val,
                                            input int unsigned mod_default,
                                            input int unsigned width);
        int unsigned mv;
        mv = mod_val & ((32'd1 << width) - 32'd1);
        if (mv == 0)
            return mod_default;
        else if (mv < 2)
            return 2;
        else
            return mv;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/modn_counter_next.sv
// modn_next: combinational next-count step for the modulo-N counter.
//   q_i      [WIDTH-1:0] current count
//   m_i      [WIDTH:0]   effective modulus M (one bit wider so 2^WIDTH fits)
//   up_dn_i              1 = up, 0 = down
//   next_q_o [WIDTH-1:0] count after one enabled step
//   wrap_o               step crossed the modulus boundary
module modn_next
    import modn_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH:0]   m_i,
    input  logic             up_dn_i,
    output logic [WIDTH-1:0] next_q_o,
    output logic             wrap_o
);

    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    logic [WIDTH:0] qx;
    logic [WIDTH:0] m_last;

    assign qx     = {1'b0, q_i};
    assign m_last = m_i - ONE;

    always_comb begin
        next_q_o = '0;
        wrap_o   = 1'b0;
        if (up_dn_i == DIR_UP) begin
            // >= rather than == so an out-of-range count also wraps to 0
            if (qx >= m_last) begin
                next_q_o = '0;
                wrap_o   = 1'b1;
            end else begin
                next_q_o = WIDTH'(qx + ONE);
            end
        end else begin
            if (q_i == '0) begin
                next_q_o = WIDTH'(m_last);
                wrap_o   = 1'b1;
            end else if (qx >= m_i) begin
                // out-of-range count recovers to the top of the range
                next_q_o = WIDTH'(m_last);
            end else begin
                next_q_o = WIDTH'(qx - ONE);
            end
        end
    end

endmodule

// File: rtl/modn_counter.sv
// modn_counter: synchronous modulo-N up/down counter with runtime modulus,
// synchronous clear/load, combinational terminal count and registered wrap
// pulse. Optional Gray-coded count output when MODN_COUNTER_GRAY_EN is defined.
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   en        count enable
//   up_dn     1 = up, 0 = down
//   clr       synchronous clear (highest priority)
//   load      synchronous parallel load of load_val
//   load_val  [WIDTH-1:0] load value (taken verbatim)
//   mod_val   [WIDTH-1:0] runtime modulus; 0 = MOD_DEFAULT, 1 acts as 2
//   q         [WIDTH-1:0] current count
//   tc        terminal count, for cascading into the next stage's en
//   wrap_p    high while q shows a freshly wrapped value
//   q_gray    [WIDTH-1:0] registered Gray code of q (MODN_COUNTER_GRAY_EN only)
module modn_counter
    import modn_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned MOD_DEFAULT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap_p
`ifdef MODN_COUNTER_GRAY_EN
   ,output logic [WIDTH-1:0] q_gray
`endif
);

    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] step_q;
    logic             step_wrap;

    assign m = (WIDTH+1)'(eff_mod(32'(mod_val), MOD_DEFAULT, WIDTH));

    modn_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q_i      (q_q),
        .m_i      (m),
        .up_dn_i  (up_dn),
        .next_q_o (step_q),
        .wrap_o   (step_wrap)
    );

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d    = step_q;
            wrap_d = step_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign tc = en & ((up_dn == DIR_UP) ? ({1'b0, q_q} >= (m - ONE))
                                        : (q_q == '0));

    assign q      = q_q;
    assign wrap_p = wrap_q;

`ifdef MODN_COUNTER_GRAY_EN
    logic [WIDTH-1:0] gray_q;

    // Encoded from q_d so the Gray value lands on the same edge as q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            gray_q <= '0;
        else
            gray_q <= WIDTH'(bin2gray(32'(q_d)));
    end

    assign q_gray = gray_q;
`endif

endmodule

// File: tb/tb_modn_counter.sv
module tb_modn_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up_dn = 1'b1, clr = 1'b0, load = 1'b0;
    logic [2:0] load_val = '0, mod_val = '0;

    logic [2:0] q_a, q_b, q_8;
    logic       tc_a, tc_b, tc_8;
    logic       wr_a, wr_b, wr_8;
`ifdef MODN_COUNTER_GRAY_EN
    logic [2:0] g_a, g_b, g_8;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // stage A: main DUT, M default 5
    modn_counter #(.WIDTH(3), .MOD_DEFAULT(5)) u_a (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .mod_val(mod_val), .q(q_a), .tc(tc_a), .wrap_p(wr_a)
`ifdef MODN_COUNTER_GRAY_EN
        , .q_gray(g_a)
`endif
    );

    // stage B: cascaded behind A
    modn_counter #(.WIDTH(3), .MOD_DEFAULT(5)) u_b (
        .clk(clk), .rst(rst), .en(tc_a), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
        .load_val(3'd0), .mod_val(3'd0), .q(q_b), .tc(tc_b), .wrap_p(wr_b)
`ifdef MODN_COUNTER_GRAY_EN
        , .q_gray(g_b)
`endif
    );

    // default modulus 8 = 2^WIDTH, shares A's inputs
    modn_counter #(.WIDTH(3), .MOD_DEFAULT(8)) u_8 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .mod_val(mod_val), .q(q_8), .tc(tc_8), .wrap_p(wr_8)
`ifdef MODN_COUNTER_GRAY_EN
        , .q_gray(g_8)
`endif
    );

    typedef struct {
        logic       en, up, clr, ld;
        logic [2:0] lv, mv;
        logic [2:0] eq;
        logic       etc, ewr;
        string      nm;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic u, input logic c, input logic l,
                       input int lv, input int mv, input int eq, input logic etc,
                       input logic ewr, input string nm);
        vec_t v;
        v.en = e; v.up = u; v.clr = c; v.ld = l;
        v.lv = 3'(lv); v.mv = 3'(mv); v.eq = 3'(eq);
        v.etc = etc; v.ewr = ewr; v.nm = nm;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic e, input logic u, input logic c, input logic l,
                         input int lv, input int mv);
        @(negedge clk);
        en = e; up_dn = u; clr = c; load = l;
        load_val = 3'(lv); mod_val = 3'(mv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        #1;
        chk("reset_q", q_a, 0);
        chk("reset_wrap", wr_a, 0);
        @(negedge clk);
        rst = 1'b1;

        // ---- vector table: {en,up,clr,load,lv,mv} -> {q,tc,wrap} ----
        // default mod-5 up, 12 clocks
        add(1,1,0,0,0,0, 1,0,0,"up1");  add(1,1,0,0,0,0, 2,0,0,"up2");
        add(1,1,0,0,0,0, 3,0,0,"up3");  add(1,1,0,0,0,0, 4,1,0,"up4");
        add(1,1,0,0,0,0, 0,0,1,"up5");  add(1,1,0,0,0,0, 1,0,0,"up6");
        add(1,1,0,0,0,0, 2,0,0,"up7");  add(1,1,0,0,0,0, 3,0,0,"up8");
        add(1,1,0,0,0,0, 4,1,0,"up9");  add(1,1,0,0,0,0, 0,0,1,"up10");
        add(1,1,0,0,0,0, 1,0,0,"up11"); add(1,1,0,0,0,0, 2,0,0,"up12");
        // clear, then down with mod_val=6
        add(0,0,1,0,0,6, 0,0,0,"clr");
        add(1,0,0,0,0,6, 5,0,1,"dn1");  add(1,0,0,0,0,6, 4,0,0,"dn2");
        add(1,0,0,0,0,6, 3,0,0,"dn3");  add(1,0,0,0,0,6, 2,0,0,"dn4");
        add(1,0,0,0,0,6, 1,0,0,"dn5");  add(1,0,0,0,0,6, 0,1,0,"dn6");
        add(1,0,0,0,0,6, 5,0,1,"dn7");
        // priority clr > load > en
        add(1,1,1,1,2,0, 0,0,0,"pri_clr");
        add(1,1,0,1,2,0, 2,0,0,"pri_load");
        add(1,1,0,1,7,0, 7,1,0,"load7_tc");
        add(1,1,0,0,0,0, 0,0,1,"oor_up_wrap");
        // out-of-range down recovery, then hold
        add(1,0,0,1,7,0, 7,0,0,"load7_dn");
        add(1,0,0,0,0,0, 4,0,0,"oor_dn");
        add(0,0,0,0,0,0, 4,0,0,"hold");
        // direction change every cycle
        add(1,1,0,0,0,0, 0,0,1,"alt_up");
        add(1,0,0,0,0,0, 4,0,1,"alt_dn");
        // mod_val=1 behaves as M=2
        add(1,1,0,0,0,1, 0,0,1,"m1_a");
        add(1,1,0,0,0,1, 1,1,0,"m1_b");
        add(1,1,0,0,0,1, 0,0,1,"m1_c");
        // modulus lowered below q
        add(0,1,0,1,3,0, 3,0,0,"ld3");
        add(1,1,0,0,0,2, 0,0,1,"lower_m");

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].up, vecs[i].clr, vecs[i].ld, int'(vecs[i].lv), int'(vecs[i].mv));
            chk({vecs[i].nm, "_q"}, q_a, vecs[i].eq);
            chk({vecs[i].nm, "_tc"}, tc_a, vecs[i].etc);
            chk({vecs[i].nm, "_wrap"}, wr_a, vecs[i].ewr);
        end

        // ---- runtime modulus on the M=8 instance ----
        drive(0,1,0,1,6,0); chk("rt_load6", q_8, 6);
        drive(1,1,0,0,0,4); chk("rt_up_m4", q_8, 0); chk("rt_up_m4_wrap", wr_8, 1);
        drive(0,1,0,1,6,0); chk("rt_load6b", q_8, 6);
        drive(1,0,0,0,0,4); chk("rt_dn_m4", q_8, 3); chk("rt_dn_m4_wrap", wr_8, 0);
        drive(1,1,0,1,7,0); chk("m8_q7", q_8, 7); chk("m8_tc", tc_8, 1);
        drive(1,1,0,0,0,0); chk("m8_wrap_q", q_8, 0); chk("m8_wrap_p", wr_8, 1);

        // ---- asynchronous reset mid-count ----
        drive(0,1,1,0,0,0);
        drive(1,1,0,0,0,0); drive(1,1,0,0,0,0); drive(1,1,0,0,0,0);
        chk("pre_rst_q", q_a, 3);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_q", q_a, 0);
        chk("async_rst_wrap", wr_a, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1; chk("rel_q1", q_a, 1);
        @(posedge clk); #1; chk("rel_q2", q_a, 2);

        // ---- cascade A -> B, 25 clocks ----
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1; up_dn = 1'b1; clr = 1'b0; load = 1'b0; mod_val = '0;
        #1;
        chk("casc_rst_b", q_b, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            chk($sformatf("casc_a%0d", c), q_a, c % 5);
            chk($sformatf("casc_b%0d", c), q_b, (c / 5) % 5);
`ifdef MODN_COUNTER_GRAY_EN
            chk($sformatf("gray_a%0d", c), g_a, (c % 5) ^ ((c % 5) >> 1));
            chk($sformatf("gray_b%0d", c), g_b, ((c / 5) % 5) ^ (((c / 5) % 5) >> 1));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
